// File: rtl/gzip_stored_inflate.sv
// gzip_stored_inflate: decodes a gzip member whose DEFLATE payload holds only
// stored blocks. Bytes arrive from a FWFT FIFO and the payload is passed straight
// to an output FIFO. CRC32 and ISIZE are recomputed and checked against the
// trailer, and the results are held in sticky status bits.
module gzip_stored_inflate (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din_in,
  input  logic        empty_in,
  output logic        rd_en_in,
  output logic [7:0]  dout_out,
  output logic        wr_en_out,
  input  logic        full_out,
  output logic        done,
  output logic        hdr_error,
  output logic        btype_error,
  output logic        len_error,
  output logic        crc_error,
  output logic        isize_error,
  output logic [31:0] crc_out,
  output logic [31:0] isize_out
);

  typedef enum logic [2:0] {
    S_HDR,
    S_BLKHDR,
    S_LEN,
    S_COPY,
    S_TRAILER,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [3:0]  byte_cnt;   // byte index within HDR / LEN / TRAILER
  logic [15:0] copy_cnt;   // payload bytes left in the current block
  logic        bfinal;
  logic        hdr_bad;    // any header check failed so far
  logic [23:0] len_sr;     // LEN/NLEN bytes received so far, LSB first
  logic [55:0] trl_sr;     // trailer bytes received so far, LSB first
  logic [31:0] crc_reg;    // non-inverted CRC register
  logic [31:0] isize_reg;

  logic        take;       // a byte is consumed this cycle
  logic        xfer;       // a payload byte is passed through this cycle
  logic        hdr_byte_bad;
  logic [31:0] len_word;
  logic [63:0] trl_word;
  logic [31:0] crc_next;

  // Reflected CRC32 (poly 0xEDB88320), one byte processed LSB first.
  function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state, consume/transfer strobes and assembled multi-byte fields.
  always_comb begin
    state_next   = state;
    take         = 1'b0;
    xfer         = 1'b0;
    len_word     = {din_in, len_sr};
    trl_word     = {din_in, trl_sr};
    crc_next     = crc_update(crc_reg, din_in);
    hdr_byte_bad = 1'b0;
    case (byte_cnt)
      4'd0:    hdr_byte_bad = (din_in != 8'h1F);
      4'd1:    hdr_byte_bad = (din_in != 8'h8B);
      4'd2:    hdr_byte_bad = (din_in != 8'h08);
      4'd3:    hdr_byte_bad = (din_in != 8'h00);
      default: hdr_byte_bad = 1'b0;
    endcase
    case (state)
      S_HDR: begin
        take = !empty_in;
        if (take && byte_cnt == 4'd9) begin
          state_next = (hdr_bad || hdr_byte_bad) ? S_ERR : S_BLKHDR;
        end
      end
      S_BLKHDR: begin
        take = !empty_in;
        if (take) begin
          state_next = (din_in[2:1] != 2'b00) ? S_ERR : S_LEN;
        end
      end
      S_LEN: begin
        take = !empty_in;
        if (take && byte_cnt == 4'd3) begin
          if (len_word[31:16] != ~len_word[15:0]) begin
            state_next = S_ERR;
          end else if (len_word[15:0] == 16'h0000) begin
            state_next = bfinal ? S_TRAILER : S_BLKHDR;
          end else begin
            state_next = S_COPY;
          end
        end
      end
      S_COPY: begin
        take = !empty_in && !full_out;
        xfer = take;
        if (take && copy_cnt == 16'd1) begin
          state_next = bfinal ? S_TRAILER : S_BLKHDR;
        end
      end
      S_TRAILER: begin
        take = !empty_in;
        if (take && byte_cnt == 4'd7) begin
          state_next = S_DONE;
        end
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

  assign rd_en_in  = take && !rst;
  assign wr_en_out = xfer && !rst;
  assign dout_out  = din_in;
  assign crc_out   = ~crc_reg;
  assign isize_out = isize_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR;
    end else begin
      state <= state_next;
    end
  end

  // Field capture, counters, CRC/ISIZE accumulation and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      copy_cnt    <= '0;
      bfinal      <= 1'b0;
      hdr_bad     <= 1'b0;
      len_sr      <= '0;
      trl_sr      <= '0;
      crc_reg     <= '1;
      isize_reg   <= '0;
      done        <= 1'b0;
      hdr_error   <= 1'b0;
      btype_error <= 1'b0;
      len_error   <= 1'b0;
      crc_error   <= 1'b0;
      isize_error <= 1'b0;
    end else if (take) begin
      case (state)
        S_HDR: begin
          hdr_bad <= hdr_bad | hdr_byte_bad;
          if (byte_cnt == 4'd9) begin
            byte_cnt <= '0;
            if (hdr_bad || hdr_byte_bad) begin
              hdr_error <= 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_BLKHDR: begin
          bfinal   <= din_in[0];
          byte_cnt <= '0;
          if (din_in[2:1] != 2'b00) begin
            btype_error <= 1'b1;
          end
        end
        S_LEN: begin
          len_sr <= {din_in, len_sr[23:8]};
          if (byte_cnt == 4'd3) begin
            byte_cnt <= '0;
            copy_cnt <= len_word[15:0];
            if (len_word[31:16] != ~len_word[15:0]) begin
              len_error <= 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_COPY: begin
          copy_cnt  <= copy_cnt - 16'd1;
          crc_reg   <= crc_next;
          isize_reg <= isize_reg + 32'd1;
        end
        S_TRAILER: begin
          trl_sr <= {din_in, trl_sr[55:8]};
          if (byte_cnt == 4'd7) begin
            byte_cnt    <= '0;
            done        <= 1'b1;
            crc_error   <= (trl_word[31:0] != ~crc_reg);
            isize_error <= (trl_word[63:32] != isize_reg);
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        default: begin
          byte_cnt <= byte_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_stored_inflate.sv
// Testbench for gzip_stored_inflate: builds gzip streams in queues, drives them
// through a FWFT-style source with random gaps and backpressure, and compares
// the decoded bytes, CRC/ISIZE and status bits to a reference model.
module tb_gzip_stored_inflate;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_in;
  logic        empty_in;
  logic        rd_en_in;
  logic [7:0]  dout_out;
  logic        wr_en_out;
  logic        full_out;
  logic        done, hdr_error, btype_error, len_error, crc_error, isize_error;
  logic [31:0] crc_out, isize_out;

  gzip_stored_inflate dut (
    .clk(clk), .rst(rst), .din_in(din_in), .empty_in(empty_in), .rd_en_in(rd_en_in),
    .dout_out(dout_out), .wr_en_out(wr_en_out), .full_out(full_out), .done(done),
    .hdr_error(hdr_error), .btype_error(btype_error), .len_error(len_error),
    .crc_error(crc_error), .isize_error(isize_error), .crc_out(crc_out), .isize_out(isize_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim[$];
  logic [7:0]  pay[$];
  logic [7:0]  blk[$];
  logic [7:0]  outq[$];
  logic [31:0] crc_tab[256];
  int          exp_consumed;
  logic [5:0]  exp_status;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay[i]) c = crc_tab[(c ^ {24'h0, pay[i]}) & 32'hFF] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic add_header(input logic [7:0] b0);
    stim.push_back(b0); stim.push_back(8'h8B); stim.push_back(8'h08); stim.push_back(8'h00);
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
  endtask

  // Emits one stored block holding the contents of blk.
  task automatic add_block(input logic fin);
    logic [15:0] len;
    len = 16'(blk.size());
    stim.push_back({5'($urandom), 2'b00, fin});
    stim.push_back(len[7:0]);  stim.push_back(len[15:8]);
    stim.push_back(~len[7:0]); stim.push_back(~len[15:8]);
    foreach (blk[i]) begin
      stim.push_back(blk[i]);
      pay.push_back(blk[i]);
    end
    blk.delete();
  endtask

  task automatic rand_blk(input int n);
    for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
  endtask

  // corrupt: 0 none, 1 CRC byte flipped, 2 ISIZE byte flipped
  task automatic add_trailer(input int corrupt);
    logic [31:0] c, s;
    c = model_crc();
    s = 32'(pay.size());
    if (corrupt == 1) c = c ^ 32'h0000_4000;
    if (corrupt == 2) s = s ^ 32'h0000_0001;
    for (int i = 0; i < 4; i++) stim.push_back(8'(c >> (8 * i)));
    for (int i = 0; i < 4; i++) stim.push_back(8'(s >> (8 * i)));
  endtask

  task automatic add_junk();
    exp_consumed = stim.size();
    for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; empty_in = 1'b0; din_in = 8'h1F; full_out = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_rd_en", rd_en_in, 1'b0);
    check("rst_wr_en", wr_en_out, 1'b0);
    check("rst_crc", crc_out, 32'h0);
    check("rst_isize", isize_out, 32'h0);
    check("rst_status", {done, hdr_error, btype_error, len_error, crc_error, isize_error}, 6'h0);
    @(negedge clk);
    rst = 1'b0; empty_in = 1'b1;
  endtask

  task automatic new_test();
    stim.delete(); pay.delete(); blk.delete(); outq.delete();
    do_reset();
  endtask

  // Streams stim into the DUT until a terminal status, budget expiry or abort.
  task automatic run(input string name, input int gap_pct, input int full_pct, input int abort_after);
    int idx, cyc, viol, tail, budget, mism;
    logic took;
    idx = 0; cyc = 0; viol = 0; tail = 0;
    budget = stim.size() * 30 + 200;
    while (!(done || hdr_error || btype_error || len_error) && cyc < budget &&
           !(abort_after != 0 && cyc == abort_after)) begin
      @(negedge clk);
      empty_in = (idx >= stim.size()) || (gap_pct != 0 && $urandom_range(99) < gap_pct);
      din_in   = (idx < stim.size()) ? stim[idx] : 8'h00;
      full_out = (full_pct != 0 && $urandom_range(99) < full_pct);
      #1;
      if (rd_en_in && empty_in) viol++;
      if (wr_en_out && (full_out || !rd_en_in || dout_out != din_in)) viol++;
      if (wr_en_out) outq.push_back(dout_out);
      took = rd_en_in;
      @(posedge clk);
      #1;
      if (took) idx++;
      cyc++;
    end
    if (abort_after != 0) return;
    check({name, "_terminated"}, (done || hdr_error || btype_error || len_error), 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      empty_in = (idx >= stim.size());
      din_in   = (idx < stim.size()) ? stim[idx] : 8'h00;
      full_out = 1'b0;
      #1;
      if (rd_en_in || wr_en_out) tail++;
      @(posedge clk);
    end
    empty_in = 1'b1;
    mism = 0;
    for (int i = 0; i < outq.size() && i < pay.size(); i++) if (outq[i] != pay[i]) mism++;
    check({name, "_protocol"}, viol, 0);
    check({name, "_rd_after_end"}, tail, 0);
    check({name, "_consumed"}, idx, exp_consumed);
    check({name, "_nbytes"}, outq.size(), pay.size());
    check({name, "_data"}, mism, 0);
    check({name, "_crc"}, crc_out, model_crc());
    check({name, "_isize"}, isize_out, 32'(pay.size()));
    check({name, "_status"}, {done, hdr_error, btype_error, len_error, crc_error, isize_error}, exp_status);
  endtask

  initial begin
    logic [31:0] c;
    int nb;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    rst = 1'b1; empty_in = 1'b1; din_in = 8'h00; full_out = 1'b0;

    // Single block "abc"
    new_test();
    add_header(8'h1F); blk = '{8'h61, 8'h62, 8'h63}; add_block(1'b1); add_trailer(0); add_junk();
    exp_status = 6'b100000;
    run("abc", 0, 0, 0);
    check("abc_crc_const", crc_out, 32'h352441C2);

    // Empty file
    new_test();
    add_header(8'h1F); add_block(1'b1); add_trailer(0); add_junk();
    exp_status = 6'b100000;
    run("empty", 0, 0, 0);

    // Two blocks with input gaps
    new_test();
    add_header(8'h1F); blk = '{8'h61, 8'h62}; add_block(1'b0);
    blk = '{8'h63}; add_block(1'b1); add_trailer(0); add_junk();
    exp_status = 6'b100000;
    run("two_blk", 40, 0, 0);
    check("two_blk_crc_const", crc_out, 32'h352441C2);

    // 1000-byte block with random backpressure
    new_test();
    add_header(8'h1F); rand_blk(1000); add_block(1'b1); add_trailer(0); add_junk();
    exp_status = 6'b100000;
    run("bp1000", 10, 50, 0);

    // Random multi-block streams, including zero-length blocks
    for (int r = 0; r < 6; r++) begin
      new_test();
      add_header(8'h1F);
      nb = $urandom_range(3, 1);
      for (int b = 0; b < nb; b++) begin
        rand_blk($urandom_range(40, 0));
        add_block(b == nb - 1);
      end
      add_trailer(0); add_junk();
      exp_status = 6'b100000;
      run("rand", 25, 30, 0);
    end

    // Error cases
    new_test();
    add_header(8'h1E); add_junk();
    exp_status = 6'b010000;
    run("hdr_err", 0, 0, 0);

    new_test();
    add_header(8'h1F); stim.push_back(8'h03); add_junk();
    exp_status = 6'b001000;
    run("btype_err", 0, 0, 0);

    new_test();
    add_header(8'h1F); stim.push_back(8'h01);
    stim.push_back(8'h03); stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'hFF);
    add_junk();
    exp_status = 6'b000100;
    run("len_err", 0, 0, 0);

    new_test();
    add_header(8'h1F); blk = '{8'h61, 8'h62, 8'h63}; add_block(1'b1); add_trailer(1); add_junk();
    exp_status = 6'b100010;
    run("crc_err", 0, 0, 0);

    new_test();
    add_header(8'h1F); rand_blk(17); add_block(1'b1); add_trailer(2); add_junk();
    exp_status = 6'b100001;
    run("isize_err", 10, 10, 0);

    // Reset mid-COPY, then a clean "abc" stream
    new_test();
    add_header(8'h1F); rand_blk(1000); add_block(1'b1); add_trailer(0); add_junk();
    run("abort", 0, 0, 200);
    new_test();
    add_header(8'h1F); blk = '{8'h61, 8'h62, 8'h63}; add_block(1'b1); add_trailer(0); add_junk();
    exp_status = 6'b100000;
    run("after_rst", 0, 0, 0);
    check("after_rst_crc_const", crc_out, 32'h352441C2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gzip_stored_inflate.md
# gzip_stored_inflate

Byte-stream gzip decoder for members whose DEFLATE payload uses only stored blocks (BTYPE=00). It is the receive-side counterpart of the GZIP compressor core: it loops compressor output back through the host link for self-checking and decodes host-supplied gzip files. It sits between a first-word-fall-through input byte FIFO and an output byte FIFO on `bus_clk`. It recomputes CRC32 and ISIZE and checks both against the trailer. Results appear as sticky status bits for the register window.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  bus clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din_in`  in  8  input byte; valid whenever `empty_in`=0 (FWFT).
- `empty_in`  in  1  input FIFO empty.
- `rd_en_in`  out  1  consume `din_in` this cycle; asserted only when `empty_in`=0.
- `dout_out`  out  8  decoded payload byte.
- `wr_en_out`  out  1  write `dout_out` to the output FIFO this cycle.
- `full_out`  in  1  output FIFO full.
- `done`  out  1  trailer consumed and all checks complete; sticky.
- `hdr_error`  out  1  bad ID1/ID2/CM, or FLG≠0; sticky.
- `btype_error`  out  1  block BTYPE≠00; sticky.
- `len_error`  out  1  NLEN ≠ ~LEN; sticky.
- `crc_error`  out  1  trailer CRC32 ≠ computed CRC; sticky.
- `isize_error`  out  1  trailer ISIZE ≠ payload byte count mod 2^32; sticky.
- `crc_out`  out  32  running CRC32 of the emitted payload (final-XORed value).
- `isize_out`  out  32  count of payload bytes emitted, mod 2^32.

## Operation
- State machine: HDR → BLKHDR → LEN → COPY → (BLKHDR | TRAILER) → DONE; any check failure → ERR.
- HDR: consumes 10 bytes. Byte0 must be 0x1F, byte1 0x8B, byte2 0x08, byte3 (FLG) 0x00. Bytes 4–9 (MTIME, XFL, OS) are ignored. The header is checked fully, then goes to ERR with `hdr_error` if any check failed.
- BLKHDR: consumes 1 byte. Bit0 = BFINAL (latched). Bits 2:1 = BTYPE; a nonzero BTYPE → ERR with `btype_error`. Bits 7:3 are discarded (byte alignment).
- LEN: consumes 4 bytes: LEN little-endian, then NLEN little-endian. NLEN≠~LEN → ERR with `len_error`. LEN=0 skips COPY.
- COPY: a 16-bit down-counter is loaded with LEN. In each transfer cycle:
  - `rd_en_in`=`wr_en_out`=1 and `dout_out`=`din_in` (combinational passthrough).
  - The CRC and ISIZE are updated and the counter decrements.
  - A transfer cycle requires `empty_in`=0 and `full_out`=0.
  - When the counter reaches 0: BFINAL=1 → TRAILER, else → BLKHDR.
- TRAILER: consumes 8 bytes: CRC32 little-endian, then ISIZE little-endian. Then `crc_error` and `isize_error` are set as applicable, `done`=1, and the machine goes to DONE.
- Byte consumption outside COPY: `rd_en_in` = !`empty_in`, independent of `full_out`.
- DONE and ERR are terminal: `rd_en_in`=0, `wr_en_out`=0. They are left only by `rst`.
- CRC32 definition:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - One byte per cycle, combinational 8-step update.
  - `crc_out` = internal register XOR 0xFFFFFFFF.
- ISIZE wraps modulo 2^32.
- Trailing bytes after the trailer are not consumed.

## Timing
- Reset values: state=HDR, all status bits 0, `crc_out`=0x00000000 (internal 0xFFFFFFFF), `isize_out`=0, counters 0, `rd_en_in`=0, `wr_en_out`=0, `dout_out`=`din_in` (don't-care when `wr_en_out`=0).
- `rst` mid-stream aborts immediately; the next cycle expects a fresh header. The caller also resets the FIFOs.
- Throughput: 1 byte per cycle in every state when not stalled.
- Latency: 0 cycles input→output in COPY.
- Status, `crc_out` and `isize_out` update on the clock edge after the consuming cycle.
- `done` rises on the edge after the 8th trailer byte is consumed. Error bits are valid on that same edge.
- Stall: in COPY, `empty_in`=1 or `full_out`=1 holds all state. Bytes are never dropped or duplicated.
- Error bits never clear except by `rst`. `done` and ERR are mutually exclusive.

## Test plan
- Single block "abc": 1F 8B 08 00 ×4(00) 00 FF, 01, 03 00 FC FF, 61 62 63, C2 41 24 35, 03 00 00 00 → outputs 61 62 63; `crc_out`=0x352441C2, `isize_out`=3, `done`=1, no errors.
- Empty file: header, 01 00 00 FF FF, 8× 00 → no `wr_en_out`; `crc_out`=0, `done`=1.
- Two blocks: 00 02 00 FD FF "ab", then 01 01 00 FE FF "c", trailer for "abc" → 3 bytes out, `done`=1. Random `empty_in` gaps must not change the result.
- Backpressure: `full_out` toggled randomly during a 1000-byte block → output equals input, no extra `rd_en_in` while `full_out`=1.
- Errors, one each:
  - byte0=0x1E → `hdr_error`.
  - block byte 0x03 → `btype_error`.
  - NLEN 0xFFFF with LEN=3 → `len_error`.
  - Corrupted CRC byte → `crc_error`, `done`=1.
  - In every case `rd_en_in` stays 0 afterwards.
- `rst` pulse mid-COPY, then a clean "abc" stream → `crc_out`=0x352441C2, `isize_out`=3, all errors 0.
